// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: releases per-stage resets one at a time, each gated by its ready ack.
// Optional per-stage ready timeout with automatic retry is enabled by defining RST_SEQ_TIMEOUT_EN.
module reset_release_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGE_DELAY    = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SW_RST_REQ,
    input  logic [NUM_STAGES-1:0] STAGE_READY,
    output logic [NUM_STAGES-1:0] STAGE_RST,
    output logic [3:0]            STAGE_IDX,
    output logic                  BUSY,
    output logic                  ALL_RELEASED,
    output logic                  TIMEOUT_ERR
);

    localparam int MAX_HD  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAX_ALL = (MAX_HD > TIMEOUT_CYCLES) ? MAX_HD : TIMEOUT_CYCLES;
    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("reset_release_sequencer: NUM_STAGES must be in 1..16");
    end
    if (HOLD_CYCLES < 1 || STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_delays
        $error("reset_release_sequencer: HOLD_CYCLES, STAGE_DELAY and TIMEOUT_CYCLES must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 63 || 64'(MAX_ALL) > CNT_LIMIT) begin : g_bad_cnt_w
        $error("reset_release_sequencer: CNT_W too narrow for the configured cycle counts");
    end

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_WAIT_RDY,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [NUM_STAGES-1:0] STAGE0_MASK = NUM_STAGES'(1);
    localparam logic [3:0]            LAST_IDX    = 4'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  busy_q, busy_d;
    logic                  all_rel_q, all_rel_d;
    logic [15:0]           ready_pad;
    logic                  ready_sel;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_err_q, timeout_err_d;
`endif

    // Padding to 16 bits lets the 4-bit stage index select the awaited ready bit directly.
    assign ready_pad = 16'(STAGE_READY);
    assign ready_sel = ready_pad[idx_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        busy_d      = busy_q;
        all_rel_d   = all_rel_q;
`ifdef RST_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif
        if (SW_RST_REQ) begin
            stage_rst_d = '1;
            all_rel_d   = 1'b0;
            busy_d      = 1'b1;
            idx_d       = '0;
            cnt_d       = '0;
            state_d     = ST_HOLD;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        stage_rst_d = stage_rst_q & ~STAGE0_MASK;
                        idx_d       = '0;
                        cnt_d       = '0;
                        state_d     = ST_WAIT_RDY;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_RDY: begin
                    // A ready seen on the timeout edge still counts as success.
                    if (ready_sel) begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            all_rel_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        stage_rst_d   = '1;
                        timeout_err_d = 1'b1;
                        idx_d         = '0;
                        cnt_d         = '0;
                        state_d       = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        stage_rst_d = stage_rst_q & ~(STAGE0_MASK << (idx_q + 4'd1));
                        idx_d       = idx_q + 4'd1;
                        cnt_d       = '0;
                        state_d     = ST_WAIT_RDY;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    stage_rst_d = '1;
                    all_rel_d   = 1'b0;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            busy_q      <= 1'b1;
            all_rel_q   <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            busy_q      <= busy_d;
            all_rel_q   <= all_rel_d;
`ifdef RST_SEQ_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign STAGE_RST    = stage_rst_q;
    assign STAGE_IDX    = idx_q;
    assign BUSY         = busy_q;
    assign ALL_RELEASED = all_rel_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign TIMEOUT_ERR  = timeout_err_q;
`else
    assign TIMEOUT_ERR  = 1'b0;
`endif

endmodule
